rpn_result_uart_tx: RTL

Transmit-side companion to the RPN UART computer's receive path. Accepts one 16-bit two's-complement result from the evaluator over a valid/ready handshake, converts it to decimal ASCII (optional leading '-', no leading zeros) and serialises it as 8N1 UART frames, terminated by a line feed (0x0A). Its `tx_out` drives the top-level `rx_out` line back to the host.

---
 rtl/rpn_result_uart_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rpn_result_uart_tx.sv
// rtl/rpn_result_uart_tx.sv - prints a 16-bit signed result as decimal ASCII plus LF over 8N1 UART
module rpn_result_uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] result,
  input  logic        result_valid,
  output logic        result_ready,
  output logic        tx_out,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SIGN, DIGIT, SEND, NL} state_t;
  typedef enum logic [1:0] {K_SIGN, K_DIGIT, K_NL} kind_t;

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

  state_t      state;
  kind_t       kind;
  logic [CW-1:0] clk_cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  shreg;
  logic [16:0] mag;
  logic [2:0]  pidx;
  logic [3:0]  d;
  logic        started;
  logic [16:0] pow;
  logic [16:0] ext;

  always_comb begin
    pow = 17'd1;
    case (pidx)
      3'd0:    pow = 17'd10000;
      3'd1:    pow = 17'd1000;
      3'd2:    pow = 17'd100;
      3'd3:    pow = 17'd10;
      default: pow = 17'd1;
    endcase
  end

  // Sign-extend to 17 bits so that -32768 negates to +32768 without overflow.
  assign ext = {result[15], result};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      kind         <= K_SIGN;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      mag          <= '0;
      pidx         <= '0;
      d            <= '0;
      started      <= 1'b0;
      tx_out       <= 1'b1;
      busy         <= 1'b0;
      result_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (result_valid) begin
            mag          <= result[15] ? (~ext + 17'd1) : ext;
            pidx         <= '0;
            d            <= '0;
            started      <= 1'b0;
            busy         <= 1'b1;
            result_ready <= 1'b0;
            state        <= result[15] ? SIGN : DIGIT;
          end
        end
        SIGN: begin
          shreg   <= 8'h2D;
          kind    <= K_SIGN;
          tx_out  <= 1'b0;
          clk_cnt <= '0;
          bit_idx <= '0;
          state   <= SEND;
        end
        DIGIT: begin
          if (mag >= pow) begin
            mag <= mag - pow;
            d   <= d + 4'd1;
          end else if (d == 4'd0 && !started && pidx < 3'd4) begin
            pidx <= pidx + 3'd1;
          end else begin
            shreg   <= 8'h30 + {4'b0, d};
            started <= 1'b1;
            kind    <= K_DIGIT;
            tx_out  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (clk_cnt != CLK_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt <= '0;
            if (bit_idx != 4'd9) begin
              bit_idx <= bit_idx + 4'd1;
              // bit_idx 8 is the last data bit, so the next bit is the stop bit.
              if (bit_idx == 4'd8) begin
                tx_out <= 1'b1;
              end else begin
                tx_out <= shreg[0];
                shreg  <= {1'b0, shreg[7:1]};
              end
            end else begin
              case (kind)
                K_SIGN: state <= DIGIT;
                K_DIGIT: begin
                  if (pidx < 3'd4) begin
                    pidx  <= pidx + 3'd1;
                    d     <= '0;
                    state <= DIGIT;
                  end else begin
                    state <= NL;
                  end
                end
                default: begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  result_ready <= 1'b1;
                end
              endcase
            end
          end
        end
        NL: begin
          shreg   <= 8'h0A;
          kind    <= K_NL;
          tx_out  <= 1'b0;
          clk_cnt <= '0;
          bit_idx <= '0;
          state   <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
